// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: encodes the multiplier, forms 17 partial
// products and presents them column-wise to the Wallace slices through one handshake stage.
module booth_pp_gen #(
    parameter int NPP = 17,
    parameter int W   = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        x,
    input  logic [31:0]        y,
    input  logic               mul_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*NPP-1:0]   pp_cols,
    output logic [NPP-1:0]     neg
);

    logic [32:0]        xe;
    logic [34:0]        ye_ext;
    logic [W*NPP-1:0]   cols_d;
    logic [NPP-1:0]     neg_d;
    logic               take_in;

    // Returns {negative, magnitude 2, magnitude 1} for one Booth window {b[2j+1], b[2j], b[2j-1]}.
    function automatic logic [2:0] booth_decode(input logic [2:0] code);
        logic [2:0] d;
        d = 3'b000;
        case (code)
            3'b001, 3'b010: d = 3'b001;
            3'b011:         d = 3'b010;
            3'b100:         d = 3'b110;
            3'b101, 3'b110: d = 3'b101;
            default:        d = 3'b000;
        endcase
        return d;
    endfunction

    assign xe     = {mul_signed & x[31], x};
    // Bit 0 is the implicit ye[-1] = 0, so window j starts at ye_ext[2j].
    assign ye_ext = {{2{mul_signed & y[31]}}, y, 1'b0};

    always_comb begin
        logic [2:0]   code;
        logic [2:0]   dig;
        logic [W-1:0] m;
        logic [W-1:0] p;
        logic [W-1:0] pp_row;
        cols_d = '0;
        neg_d  = '0;
        code   = '0;
        dig    = '0;
        m      = '0;
        p      = '0;
        pp_row = '0;
        for (int j = 0; j < NPP; j++) begin
            code = ye_ext[2*j +: 3];
            dig  = booth_decode(code);
            if (dig[1])
                m = {{(W-34){xe[32]}}, xe, 1'b0};
            else if (dig[0])
                m = {{(W-33){xe[32]}}, xe};
            else
                m = '0;
            // A zero digit never raises neg, even when the window reads 111.
            p        = dig[2] ? ~m : m;
            pp_row   = p << (2*j);
            neg_d[j] = dig[2];
            for (int k = 0; k < W; k++)
                cols_d[k*NPP + j] = pp_row[k];
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign take_in  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            pp_cols   <= '0;
            neg       <= '0;
        end else begin
            if (take_in) begin
                out_valid <= 1'b1;
                pp_cols   <= cols_d;
                neg       <= neg_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_booth_pp_gen.sv
// Directed bench for booth_pp_gen: rebuilds the product from the column outputs
// and compares it with a reference 64-bit product.
module tb_booth_pp_gen;

    localparam int NPP = 17;
    localparam int W   = 64;

    logic               clk = 1'b0;
    logic               resetn;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        x;
    logic [31:0]        y;
    logic               mul_signed;
    logic               out_valid;
    logic               out_ready;
    logic [W*NPP-1:0]   pp_cols;
    logic [NPP-1:0]     neg;

    int n_assert = 0;
    int n_fail   = 0;

    booth_pp_gen #(.NPP(NPP), .W(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .mul_signed (mul_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pp_cols    (pp_cols),
        .neg        (neg)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] get_pp(input logic [W*NPP-1:0] c, input int j);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < W; k++)
            r[k] = c[k*NPP + j];
        return r;
    endfunction

    function automatic logic [63:0] recon(input logic [W*NPP-1:0] c, input logic [NPP-1:0] n);
        logic [63:0] s;
        logic [63:0] one;
        s = '0;
        for (int j = 0; j < NPP; j++) begin
            one = 64'd1;
            s = s + get_pp(c, j);
            if (n[j])
                s = s + (one << (2*j));
        end
        return s;
    endfunction

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ae;
        logic [63:0] be;
        ae = {{32{s & a[31]}}, a};
        be = {{32{s & b[31]}}, b};
        return ae * be;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
        in_valid   = 1'b1;
        x          = a;
        y          = b;
        mul_signed = s;
    endtask

    logic [63:0]      p1, p2, p3;
    logic [W*NPP-1:0] snap;

    initial begin
        resetn = 1'b0; in_valid = 1'b0; x = '0; y = '0; mul_signed = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_neg", 64'(neg), 64'd0);
        chk("rst_cols_zero", 64'(pp_cols == '0), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // x=3, y=2 unsigned: digit0 = -2X (PP_0 = ~6), digit1 = +X (PP_1 = 12)
        out_ready = 1'b1;
        drive(32'd3, 32'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("x3y2_valid", 64'(out_valid), 64'd1);
        chk("x3y2_col1_b0", 64'(pp_cols[1*NPP + 0]), 64'd0);
        chk("x3y2_col3_b0", 64'(pp_cols[3*NPP + 0]), 64'd1);
        chk("x3y2_col63_b0", 64'(pp_cols[63*NPP + 0]), 64'd1);
        chk("x3y2_pp0", get_pp(pp_cols, 0), 64'hFFFF_FFFF_FFFF_FFF9);
        chk("x3y2_col2_b1", 64'(pp_cols[2*NPP + 1]), 64'd1);
        chk("x3y2_col3_b1", 64'(pp_cols[3*NPP + 1]), 64'd1);
        chk("x3y2_pp1", get_pp(pp_cols, 1), 64'h0000_0000_0000_000C);
        chk("x3y2_pp2", get_pp(pp_cols, 2), 64'd0);
        chk("x3y2_neg", 64'(neg), 64'h1);
        chk("x3y2_sum", recon(pp_cols, neg), 64'd6);
        tick();
        chk("x3y2_drain", 64'(out_valid), 64'd0);

        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        tick();
        chk("s_m1_m1", recon(pp_cols, neg), 64'h0000_0000_0000_0001);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        chk("u_max_max", recon(pp_cols, neg), 64'hFFFF_FFFE_0000_0001);
        drive(32'h8000_0000, 32'h8000_0000, 1'b1);
        tick();
        chk("s_min_min", recon(pp_cols, neg), 64'h4000_0000_0000_0000);
        drive(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        tick();
        chk("s_max_min", recon(pp_cols, neg), 64'hC000_0000_8000_0000);
        in_valid = 1'b0;
        tick();

        // Backpressure: downstream stalls for 4 cycles with operations queued
        p1 = ref_prod(32'd12345, 32'hDEAD_BEEF, 1'b0);
        p2 = ref_prod(32'hF000_0001, 32'd77, 1'b1);
        p3 = ref_prod(32'h1234_5678, 32'h8765_4321, 1'b1);
        out_ready = 1'b0;
        drive(32'd12345, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("bp_op1_valid", 64'(out_valid), 64'd1);
        chk("bp_op1_sum", recon(pp_cols, neg), p1);
        snap = pp_cols;
        drive(32'hF000_0001, 32'd77, 1'b1);
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_stable", 64'(pp_cols == snap), 64'd1);
            chk("bp_hold_sum", recon(pp_cols, neg), p1);
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 64'(in_ready), 64'd1);
        tick();
        chk("bp_op2_sum", recon(pp_cols, neg), p2);
        drive(32'h1234_5678, 32'h8765_4321, 1'b1);
        tick();
        chk("bp_op3_sum", recon(pp_cols, neg), p3);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Throughput: one new operation accepted and one result presented every cycle
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = $urandom;
            b = $urandom;
            if (i % 10 == 0) a = 32'h8000_0000;
            if (i % 13 == 0) b = 32'hFFFF_FFFF;
            s = 1'($urandom_range(0, 1));
            drive(a, b, s);
            #1;
            chk("tp_in_ready", 64'(in_ready), 64'd1);
            tick();
            chk("tp_valid", 64'(out_valid), 64'd1);
            chk("tp_sum", recon(pp_cols, neg), ref_prod(a, b, s));
        end
        in_valid = 1'b0;
        tick();
        chk("tp_drain", 64'(out_valid), 64'd0);

        // Reset while a result is held: it must vanish without being transferred
        out_ready = 1'b0;
        drive(32'd99, 32'd101, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("mrst_held", 64'(out_valid), 64'd1);
        resetn = 1'b0;
        tick();
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_cols_zero", 64'(pp_cols == '0), 64'd1);
        chk("mrst_neg", 64'(neg), 64'd0);
        resetn    = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("mrst_no_stale", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
